// File: rtl/ctrl_pipe_chain_pkg.sv
// Shared definitions for the control-word pipeline: counter width default,
// the MIPS decode word layout and a helper for building per-stage keep masks.
package pipe_ctrl_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int MAX_KEEP_W = 1024;

  typedef struct packed {
    logic       regDst;
    logic       aluSrc;
    logic       memToReg;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic       branchNe;
    logic       jump;
    logic       link;
    logic       jr;
    logic       zeroExt;
    logic       shamtSel;
    logic [3:0] aluCtl;
  } ctrlWord_t;

  localparam int CTRL_W = $bits(ctrlWord_t);

  // Overwrite the slice for 1-based stage 'stage' of a flattened keep mask.
  function automatic logic [MAX_KEEP_W-1:0] keepMaskSet(
    input logic [MAX_KEEP_W-1:0] base,
    input int                    stage,
    input int                    width,
    input logic [63:0]           keep
  );
    logic [MAX_KEEP_W-1:0] m;
    m = base;
    for (int b = 0; b < width; b++) m[(stage-1)*width + b] = keep[b];
    return m;
  endfunction

endpackage

// File: rtl/ctrl_pipe_chain_stage.sv
// One control-pipeline register with valid; flush beats hold beats bubble beats load.
module ctrl_pipe_stage #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             flush,
  input  logic             hold,
  input  logic             bubble,
  input  logic [WIDTH-1:0] dIn,
  input  logic             vIn,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] q,
  output logic             v
);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      q <= '0;
      v <= 1'b0;
    end else if (flush) begin
      q <= '0;
      v <= 1'b0;
    end else if (!hold) begin
      if (bubble) begin
        q <= '0;
        v <= 1'b0;
      end else begin
        // Invalid entries are zeroed so downstream never sees stale control bits.
        v <= vIn;
        q <= vIn ? (dIn & mask) : '0;
      end
    end
  end

endmodule

// File: rtl/ctrl_pipe_chain.sv
// Parametrised ID->WB control-word pipeline with stall backpropagation,
// per-stage flush, and saturating bubble/flush event counters.
module ctrl_pipe_chain
  import pipe_ctrl_pkg::*;
#(
  parameter int                      WIDTH     = CTRL_W,
  parameter int                      STAGES    = 3,
  parameter logic [STAGES*WIDTH-1:0] KEEP_MASK = '1,
  parameter int                      CNT_W     = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        d_in,
  input  logic                    valid_in,
  input  logic [STAGES-1:0]       stall,
  input  logic [STAGES-1:0]       flush,
  output logic [STAGES*WIDTH-1:0] q_out,
  output logic [STAGES-1:0]       valid_out,
  output logic [CNT_W-1:0]        bubble_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);

  localparam int INC_W = $clog2(STAGES + 1);
  localparam int SUM_W = CNT_W + INC_W;

  logic [STAGES-1:0][WIDTH-1:0] stageQ;
  logic [STAGES-1:0]            stageV;
  logic [STAGES-1:0]            hold;
  logic [STAGES-1:0]            bubble;
  logic [STAGES-1:0]            bubFire;
  logic [INC_W-1:0]             bubInc;
  logic [INC_W-1:0]             flushInc;

  // A stall on any later stage holds this one too.
  assign hold[STAGES-1] = stall[STAGES-1];

  generate
    for (genvar i = 0; i < STAGES; i++) begin : gStage
      logic [WIDTH-1:0] prevQ;
      logic             prevV;
      if (i == 0) begin : gFirst
        assign prevQ     = d_in;
        assign prevV     = valid_in;
        assign bubble[i] = 1'b0;
      end else begin : gRest
        assign prevQ     = stageQ[i-1];
        assign prevV     = stageV[i-1];
        assign bubble[i] = hold[i-1];
      end
      if (i < STAGES - 1) begin : gHold
        assign hold[i] = stall[i] | hold[i+1];
      end
      ctrl_pipe_stage #(.WIDTH(WIDTH)) uStage (
        .clk    (clk),
        .rstN   (reset),
        .flush  (flush[i]),
        .hold   (hold[i]),
        .bubble (bubble[i]),
        .dIn    (prevQ),
        .vIn    (prevV),
        .mask   (KEEP_MASK[i*WIDTH +: WIDTH]),
        .q      (stageQ[i]),
        .v      (stageV[i])
      );
    end
  endgenerate

  assign bubFire = bubble & ~hold & ~flush;

  always_comb begin
    bubInc   = '0;
    flushInc = '0;
    for (int i = 0; i < STAGES; i++) begin
      bubInc   = bubInc + INC_W'(bubFire[i]);
      flushInc = flushInc + INC_W'(flush[i] & stageV[i]);
    end
  end

  function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] cnt,
                                               input logic [INC_W-1:0] inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(cnt) + SUM_W'(inc);
    return (sum[SUM_W-1:CNT_W] != '0) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      bubble_cnt <= satAdd(bubble_cnt, bubInc);
      flush_cnt  <= satAdd(flush_cnt, flushInc);
    end
  end

  assign q_out     = stageQ;
  assign valid_out = stageV;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Scoreboard bench: stimulus pushes expected last-stage words, negedge monitors pop and compare.
module tb_ctrl_pipe_chain;
  import pipe_ctrl_pkg::*;

  localparam int W = 17;
  localparam int S = 3;

  logic clk, rstN;
  logic [W-1:0]   dA, dB, dC;
  logic           vA, vB, vC;
  logic [S-1:0]   stA, flA, stB, flB, stC, flC;
  logic [S*W-1:0] qA, qB, qC;
  logic [S-1:0]   voA, voB, voC;
  logic [15:0]    bcA, fcA, bcB, fcB;
  logic [1:0]     bcC, fcC;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] expA[$];
  logic [W-1:0] expB[$];
  logic [W-1:0] wds [6];

  ctrl_pipe_chain #(.WIDTH(W), .STAGES(S)) dutA (
    .clk(clk), .reset(rstN), .d_in(dA), .valid_in(vA), .stall(stA), .flush(flA),
    .q_out(qA), .valid_out(voA), .bubble_cnt(bcA), .flush_cnt(fcA));

  ctrl_pipe_chain #(.WIDTH(W), .STAGES(S),
                    .KEEP_MASK({17'h1FFFF, 17'h0FFFF, 17'h1FFFF})) dutB (
    .clk(clk), .reset(rstN), .d_in(dB), .valid_in(vB), .stall(stB), .flush(flB),
    .q_out(qB), .valid_out(voB), .bubble_cnt(bcB), .flush_cnt(fcB));

  ctrl_pipe_chain #(.WIDTH(W), .STAGES(S), .CNT_W(2)) dutC (
    .clk(clk), .reset(rstN), .d_in(dC), .valid_in(vC), .stall(stC), .flush(flC),
    .q_out(qC), .valid_out(voC), .bubble_cnt(bcC), .flush_cnt(fcC));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Last-stage monitors: every valid last-stage entry must match the next expected word.
  always @(negedge clk) begin
    if (voA[2]) begin
      if (expA.size() == 0) begin
        total++; bad++;
        $display("FAIL sbA_extra act=%h exp=none", qA[50:34]);
      end else chk("sbA", {47'd0, qA[50:34]}, {47'd0, expA.pop_front()});
    end else chk("sbA_bubble_zero", {47'd0, qA[50:34]}, 64'd0);
    if (voB[2]) begin
      if (expB.size() == 0) begin
        total++; bad++;
        $display("FAIL sbB_extra act=%h exp=none", qB[50:34]);
      end else chk("sbB", {47'd0, qB[50:34]}, {47'd0, expB.pop_front()});
    end
  end

  initial begin
    int nb;
    int idx;
    logic stl;
    wds = '{17'h00011, 17'h00122, 17'h01233, 17'h12344, 17'h03455, 17'h14566};
    rstN = 1'b0;
    {dA, dB, dC} = '0;
    {vA, vB, vC} = '0;
    {stA, flA, stB, flB, stC, flC} = '0;
    #12;
    chk("rst_q", qA, 0);
    chk("rst_v", voA, 0);
    chk("rst_cnt", {bcA, fcA}, 0);
    @(posedge clk); #1;
    rstN = 1'b1;

    // Test 1: single word walks the pipe
    vA = 1'b1; dA = 17'h1ABCD; expA.push_back(17'h1ABCD);
    tick();
    chk("t1_s1", qA[16:0], 17'h1ABCD);
    chk("t1_v1", voA, 3'b001);
    vA = 1'b0; dA = '0;
    tick();
    chk("t1_s2", qA, {17'h0, 17'h1ABCD, 17'h0});
    tick();
    chk("t1_v3", voA, 3'b100);
    tick();
    chk("t1_empty_q", qA, 0);
    chk("t1_empty_v", voA, 0);

    // Test 3: stream with stall[1] for two cycles
    idx = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      stl = (cyc == 3) || (cyc == 4);
      vA  = (idx < 6);
      dA  = (idx < 6) ? wds[idx] : '0;
      stA = {1'b0, stl, 1'b0};
      tick();
      if (!stl && idx < 6) begin
        expA.push_back(wds[idx]);
        idx++;
      end
      if (stl) begin
        chk("t3_s2_frozen", qA[33:17], wds[1]);
        chk("t3_s1_frozen", qA[16:0], wds[2]);
        chk("t3_s3_bubble", {voA[2], qA[50:34]}, 0);
      end
    end
    stA = '0; vA = 1'b0; dA = '0;
    repeat (3) tick();
    chk("t3_bubble_cnt", bcA, 2);

    // Test 4: flush + stall on stage 1
    vA = 1'b1; dA = 17'h00123;
    tick();
    vA = 1'b1; dA = 17'h00456; flA = 3'b001; stA = 3'b001;
    tick();
    chk("t4_s1_cleared", {voA[0], qA[16:0]}, 0);
    chk("t4_flush_cnt", fcA, 1);
    chk("t4_bubble_cnt", bcA, 3);
    vA = 1'b0; dA = '0; stA = '0;
    tick();
    chk("t4_empty_flush", fcA, 1);
    flA = '0;
    repeat (3) tick();

    // Test 2: keep mask drops bit 16 at stage 2
    vB = 1'b1; dB = 17'h1FFFF;
    for (int k = 0; k < 3; k++) begin
      expB.push_back(17'h0FFFF);
      tick();
      if (k == 0) chk("t2_s1", qB[16:0], 17'h1FFFF);
      if (k == 1) chk("t2_s2", qB[33:17], 17'h0FFFF);
    end
    vB = 1'b0; dB = '0;
    repeat (4) tick();

    // Test 5: 2-bit counter saturates under toggling stall
    nb = 0;
    vC = 1'b1; dC = 17'h00F0F;
    for (int cyc = 0; cyc < 10; cyc++) begin
      stC = (cyc % 2 == 0) ? 3'b010 : 3'b000;
      tick();
      if (cyc % 2 == 0) nb++;
      chk("t5_bubble_sat", bcC, (nb > 3) ? 3 : nb);
    end
    stC = '0; vC = 1'b0;
    chk("t5_flush_cnt", fcC, 0);

    // Test 6: async reset mid-cycle during a stall
    vA = 1'b1; dA = 17'h0AAAA;
    tick();
    vA = 1'b0; dA = '0; stA = 3'b010;
    tick();
    #2 rstN = 1'b0;
    #1;
    chk("t6_async_q", qA, 0);
    chk("t6_async_v", voA, 0);
    chk("t6_async_cnt", {bcA, fcA}, 0);
    stA = '0;
    tick();
    chk("t6_held_q", qA, 0);
    rstN = 1'b1;
    vA = 1'b1; dA = 17'h15555; expA.push_back(17'h15555);
    tick();
    chk("t6_first_load", {voA, qA}, {3'b001, 34'd0, 17'h15555});
    vA = 1'b0; dA = '0;
    repeat (4) tick();

    chk("qA_drained", expA.size(), 0);
    chk("qB_drained", expB.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_chain.md
Name: ctrl_pipe_chain

Overview:
Parametrised control-signal pipeline that carries decoded control words from ID through any number of downstream stages.
- Generalises the fixed ID/EX/MEM/WB control registers: stage count, word width and per-stage field retention are parameters.
- Adds per-stage valid bits, per-stage stall with bubble insertion, per-stage flush, and saturating bubble/flush event counters for hazard-unit debug.
- Sits between main/ALU decode and the datapath; the hazard unit drives stall and flush.

Parameters:
WIDTH, 17, bits per control word.
STAGES, 3, number of pipeline registers (stage 1 fed from ID, stage STAGES = WB).
KEEP_MASK, all ones ({STAGES*WIDTH}), flattened per-stage mask; slice i-1 gives the bits retained when loading stage i; dropped bits read 0.
CNT_W, 16, width of event counters.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-low reset.
d_in  in  WIDTH  decoded control word from ID.
valid_in  in  1  d_in holds a real instruction.
stall  in  STAGES  stall[i-1]=1 holds stage i.
flush  in  STAGES  flush[i-1]=1 clears stage i at the next edge.
q_out  out  STAGES*WIDTH  stage contents; slice i-1 is stage i.
valid_out  out  STAGES  per-stage valid.
bubble_cnt  out  CNT_W  saturating count of inserted bubbles.
flush_cnt  out  CNT_W  saturating count of valid entries discarded by flush.

Behaviour:
- Reset (reset=0, async): all stages, valids and counters go to 0 immediately; they stay 0 while asserted. The first load occurs on the first rising edge after deassertion.
- Effective hold: hold_i = OR(stall[j-1]) for j>=i. A stall backpropagates to every earlier stage.
- Per-edge update of stage i, in priority order:
  1. flush[i-1]=1: stage and valid cleared. Flush beats hold.
  2. hold_i=1: stage unchanged.
  3. i>1 and hold_{i-1}=1: bubble loaded (word 0, valid 0).
  4. Otherwise: load the previous stage (d_in/valid_in for i=1), ANDed with KEEP_MASK slice i-1.
- A word loaded with valid 0 is forced to all zeros. Invariant: valid_out[i]=0 implies the stage word is 0.
- Latency: d_in appears in stage k exactly k edges after capture when there are no stalls or flushes. Each cycle of hold on stage k adds one cycle.
- bubble_cnt: per edge, adds the number of stages taking rule 3, counting only bubbles that replace a previously valid entry or follow a valid entry. Simplification for the RTL: add popcount of the stages where rule 3 fires. Saturates at 2^CNT_W-1 and does not wrap.
- flush_cnt: per edge, adds popcount(flush & valid_out). Flushing an empty stage is not counted. Saturating.
- Both counters are updated with a single saturating add per cycle. The adder width is CNT_W+$clog2(STAGES+1); the result is clamped.
- Simultaneous stall and flush on the same stage: the stage is flushed. Earlier stages still hold.
- stall[STAGES-1] (last stage) freezes the whole chain.
- valid_in=0 with no hold: stage 1 loads a bubble. This is not counted in bubble_cnt.
- Reset asserted mid-stall or mid-flush: everything clears; no partial state survives.
- STAGES=1 is legal: rule 3 never applies and bubble_cnt stays 0.

Decomposition:
- Shared package pipe_ctrl_pkg: CNT_W default, a KEEP_MASK builder function, and the typedef of the standard 17-bit control word with named fields for the current MIPS core.
- One natural sub-module: ctrl_pipe_stage. It is a single WIDTH-bit register plus valid, with inputs flush/hold/bubble/load and mask, and uses the async active-low reset. It is instantiated STAGES times in a generate loop.
- Counters live in the top module.

Test Plan:
1. Reset, then valid_in=1 with d_in=0x1ABCD for one cycle, STAGES=3, KEEP all ones. Required: stage1=0x1ABCD after edge 1, stage2 after edge 2, stage3 after edge 3, valid moving with the word; then all zero.
2. KEEP_MASK stage2=0x0FFFF, d_in=0x1FFFF streamed. Required: stage2=0x0FFFF, and stage3 also 0x0FFFF (bit dropped stays dropped).
3. Stream of distinct valid words, stall[1]=1 for 2 cycles. Required: stages 1–2 frozen, stage3 gets bubbles (0, valid 0) on both edges, bubble_cnt=2, the stream resumes with no word lost or duplicated.
4. flush[0]=1 while stage1 valid and stall[0]=1 in the same cycle. Required: stage1 cleared next edge, flush_cnt=1. A flush with stage1 empty leaves flush_cnt at 1.
5. CNT_W=2, continuous stall[1] toggling. Required: bubble_cnt saturates at 3 and never wraps.
6. Assert reset low asynchronously mid-cycle during a stall. Required: q_out, valid_out and counters go to 0 before the next edge. After release, the first valid_in is loaded on the first edge.
